// File: rtl/graph_pkg.sv
// Shared constants and state encoding for the graph plot blocks.
// Latency: n/a (types and parameters only).
// Backpressure: n/a.
package graph_pkg;

  localparam int X_MIN     = 30;
  localparam int Y_MAX     = 300;
  localparam int N_SAMPLES = 512;
  localparam int AW        = $clog2(N_SAMPLES);
  localparam int DW        = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/trace_ram.sv
// Ping-pong trace store: two banks of N_SAMPLES x DW, bank select in the address MSB.
// Latency: registered read, data valid one clock after the address.
// Backpressure: none; one write and one read every clock.
module trace_ram
  import graph_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW:0]   raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2*N_SAMPLES];

  // write port and registered read port; the sequencer keeps them on opposite banks
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/trace_sequencer.sv
// Captures samples into a ping-pong buffer and flags pixels lying on the displayed (line-joined) trace.
// Latency: trace_hit follows x,y by two clocks; a completed bank is shown from the cycle after frame_start.
// Backpressure: s_ready high only in FILL; the source stalls while idle and while a full trace waits for a frame.
module trace_sequencer
  import graph_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  input  logic          run,
  input  logic          single,
  output logic          capturing,
  output logic          frame_ready,
  output logic          trace_hit
);

  localparam logic [9:0]    X_LO     = 10'(X_MIN);
  localparam logic [9:0]    X_HI     = 10'(X_MIN + N_SAMPLES - 1);
  localparam logic [AW-1:0] X_LO_A   = AW'(X_MIN);
  localparam logic [AW-1:0] PTR_LAST = AW'(N_SAMPLES - 1);
  localparam logic [9:0]    ROW0     = 10'(Y_MAX);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] wr_ptr;
  logic          disp_bank;
  logic          wr_fire;
  logic          last_fire;
  logic          swap;

  logic          win;
  logic          first_col;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_q;
  logic          win_d1;
  logic          first_d1;
  logic [9:0]    y_d1;
  logic [9:0]    cur_row;
  logic [9:0]    prev_row;
  logic [9:0]    prev_eff;
  logic [9:0]    row_lo;
  logic [9:0]    row_hi;
  logic          in_range;

  // s_ready is high throughout FILL, so a valid sample in FILL is a handshake
  assign wr_fire   = (state == FILL) && s_valid;
  assign last_fire = wr_fire && (wr_ptr == PTR_LAST);
  // only a frame boundary seen while already holding a full trace swaps banks
  assign swap      = (state == DONE) && frame_start;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic: run/single arm, last handshake completes, frame boundary releases
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run || single) state_nxt = FILL;
      FILL:    if (last_fire)     state_nxt = DONE;
      DONE:    if (frame_start)   state_nxt = run ? FILL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    s_ready   = 1'b0;
    capturing = 1'b0;
    if (state == FILL) begin
      s_ready   = 1'b1;
      capturing = 1'b1;
    end
  end

  // write pointer restarts outside FILL; bank flips and display arms on the frame boundary swap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      disp_bank   <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      if (state != FILL) begin
        wr_ptr <= '0;
      end else if (wr_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (swap) begin
        disp_bank   <= ~disp_bank;
        frame_ready <= 1'b1;
      end
    end
  end

  // column window and RAM read address (modulo arithmetic on the low bits is exact inside the window)
  assign win       = (x >= X_LO) && (x <= X_HI);
  assign rd_addr   = x[AW-1:0] - X_LO_A;
  assign first_col = (rd_addr == '0);

  trace_ram u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr ({~disp_bank, wr_ptr}),
    .wdata (s_data),
    .raddr ({disp_bank, rd_addr}),
    .rdata (rd_q)
  );

  // row of the current column, and the segment joining it to the previous column
  always_comb begin
    cur_row  = ROW0 - {{(10-DW){1'b0}}, rd_q};
    prev_eff = first_d1 ? cur_row : prev_row;
    row_lo   = (prev_eff < cur_row) ? prev_eff : cur_row;
    row_hi   = (prev_eff < cur_row) ? cur_row : prev_eff;
    in_range = (y_d1 >= row_lo) && (y_d1 <= row_hi);
  end

  // display pipeline: stage 1 aligns x/y with the RAM read, stage 2 registers the hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_d1    <= 1'b0;
      first_d1  <= 1'b0;
      y_d1      <= '0;
      prev_row  <= '0;
      trace_hit <= 1'b0;
    end else begin
      win_d1    <= win;
      first_d1  <= first_col;
      y_d1      <= y;
      if (win_d1) begin
        prev_row <= cur_row;
      end
      trace_hit <= frame_ready && win_d1 && in_range;
    end
  end

endmodule

// File: tb/tb_trace_sequencer.sv
// Directed bench for trace_sequencer with a scoreboard of expected pixel hits.
// Latency: expects trace_hit two clocks after each x,y.
// Backpressure: samples are offered continuously and counted only on s_valid & s_ready.
module tb_trace_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic [9:0] x;
  logic [9:0] y;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       run;
  logic       single;
  logic       capturing;
  logic       frame_ready;
  logic       trace_hit;

  int errors = 0;
  int checks = 0;

  // reference model: next bank being written, pending full bank, displayed bank
  logic [7:0] m_wbuf [512];
  logic [7:0] m_pend [512];
  logic [7:0] m_disp [512];
  logic       m_done = 1'b0;
  logic       m_fr   = 1'b0;

  typedef struct {
    int   xv;
    logic e;
  } exp_t;

  trace_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .x           (x),
    .y           (y),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .run         (run),
    .single      (single),
    .capturing   (capturing),
    .frame_ready (frame_ready),
    .trace_hit   (trace_hit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic exp_hit(input int xv, input int yv);
    int a, cur, prv, lo, hi;
    if (!m_fr || xv < 30 || xv > 541) return 1'b0;
    a   = xv - 30;
    cur = 300 - int'(m_disp[a]);
    prv = (a == 0) ? cur : 300 - int'(m_disp[a-1]);
    lo  = (prv < cur) ? prv : cur;
    hi  = (prv < cur) ? cur : prv;
    return (yv >= lo) && (yv <= hi);
  endfunction

  // scan columns xlo..xhi on row yv (xlo left of the window so line joining starts clean)
  task automatic sweep(input int yv, input int xlo, input int xhi);
    exp_t q[$];
    exp_t it;
    for (int xv = xlo; xv <= xhi + 2; xv++) begin
      tick();
      if (q.size() >= 2) begin
        it = q.pop_front();
        check($sformatf("hit x=%0d y=%0d", it.xv, yv), {31'd0, trace_hit}, {31'd0, it.e});
      end
      if (xv <= xhi) begin
        x = 10'(xv);
        it.xv = xv;
      end else begin
        x = 10'd0;
        it.xv = 0;
      end
      y = 10'(yv);
      it.e = exp_hit(int'(x), yv);
      q.push_back(it);
    end
  endtask

  // stream m_wbuf; optional frame_start / single pulse / reset when sample index reaches *_at
  task automatic capture(input int fs_at, input int sg_at, input int rst_at);
    int   idx = 0;
    int   guard = 0;
    logic hs;
    while (idx < 512 && guard < 2000) begin
      s_valid     = 1'b1;
      s_data      = m_wbuf[idx];
      frame_start = (idx == fs_at);
      single      = (idx == sg_at);
      if (idx == rst_at) begin
        s_valid     = 1'b0;
        frame_start = 1'b0;
        single      = 1'b0;
        rst_n       = 1'b0;
        m_fr        = 1'b0;
        m_done      = 1'b0;
        #1;
        check("rst s_ready", {31'd0, s_ready}, 32'd0);
        check("rst capturing", {31'd0, capturing}, 32'd0);
        check("rst frame_ready", {31'd0, frame_ready}, 32'd0);
        check("rst trace_hit", {31'd0, trace_hit}, 32'd0);
        return;
      end
      hs = s_ready;
      tick();
      if (hs) idx++;
      guard++;
    end
    s_valid     = 1'b0;
    frame_start = 1'b0;
    single      = 1'b0;
    check("capture handshakes", idx, 512);
    if (idx == 512) begin
      m_pend = m_wbuf;
      m_done = 1'b1;
    end
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (m_done) begin
      m_disp = m_pend;
      m_fr   = 1'b1;
      m_done = 1'b0;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    x           = 10'd0;
    y           = 10'd0;
    s_valid     = 1'b0;
    s_data      = 8'd0;
    run         = 1'b0;
    single      = 1'b0;
    #2;
    check("reset s_ready", {31'd0, s_ready}, 32'd0);
    check("reset capturing", {31'd0, capturing}, 32'd0);
    check("reset frame_ready", {31'd0, frame_ready}, 32'd0);
    check("reset trace_hit", {31'd0, trace_hit}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle s_ready", {31'd0, s_ready}, 32'd0);

    // continuous capture of 0..255,0..255
    for (int i = 0; i < 512; i++) m_wbuf[i] = 8'(i);
    run = 1'b1;
    tick();
    check("run starts fill", {31'd0, capturing}, 32'd1);
    capture(-1, -1, -1);
    check("done s_ready", {31'd0, s_ready}, 32'd0);
    check("done capturing", {31'd0, capturing}, 32'd0);
    check("pre-swap frame_ready", {31'd0, frame_ready}, 32'd0);
    sweep(300, 28, 40);
    pulse_fs();
    check("swap frame_ready", {31'd0, frame_ready}, 32'd1);
    check("run refills", {31'd0, capturing}, 32'd1);
    sweep(300, 28, 36);
    sweep(299, 28, 36);
    sweep(298, 28, 36);

    // step 0 -> 200 between samples 9 and 10, frame_start mid-fill ignored
    for (int i = 0; i < 512; i++) m_wbuf[i] = (i < 10) ? 8'd0 : 8'd200;
    capture(300, -1, -1);
    check("midfill frame_ready", {31'd0, frame_ready}, 32'd1);
    sweep(100, 28, 45);
    pulse_fs();
    for (int yv = 99; yv <= 300; yv++) sweep(yv, 28, 42);

    // frame_start coincident with the last handshake waits a frame
    for (int i = 0; i < 512; i++) m_wbuf[i] = 8'd50;
    capture(511, -1, -1);
    check("coincident no swap", {31'd0, s_ready}, 32'd0);
    sweep(100, 28, 45);
    run = 1'b0;
    pulse_fs();
    check("stop idle capturing", {31'd0, capturing}, 32'd0);
    check("stop idle s_ready", {31'd0, s_ready}, 32'd0);
    sweep(250, 28, 36);
    sweep(251, 28, 36);

    // single-shot capture, second single during fill ignored
    for (int i = 0; i < 512; i++) m_wbuf[i] = 8'(i / 2);
    single = 1'b1;
    tick();
    single = 1'b0;
    check("single starts fill", {31'd0, capturing}, 32'd1);
    capture(-1, 100, -1);
    check("single done s_ready", {31'd0, s_ready}, 32'd0);
    pulse_fs();
    tick();
    tick();
    tick();
    check("single idle s_ready", {31'd0, s_ready}, 32'd0);
    check("single idle capturing", {31'd0, capturing}, 32'd0);
    sweep(300, 28, 36);
    sweep(299, 28, 36);

    // reset at sample 100 discards everything
    for (int i = 0; i < 512; i++) m_wbuf[i] = 8'd7;
    single = 1'b1;
    tick();
    single = 1'b0;
    capture(-1, -1, 100);
    tick();
    rst_n = 1'b1;
    tick();
    check("post-rst s_ready", {31'd0, s_ready}, 32'd0);
    check("post-rst frame_ready", {31'd0, frame_ready}, 32'd0);
    sweep(300, 28, 36);
    pulse_fs();
    check("no pending swap", {31'd0, frame_ready}, 32'd0);
    sweep(300, 28, 36);

    // a full capture plus swap restores the display
    for (int i = 0; i < 512; i++) m_wbuf[i] = 8'(255 - (i % 256));
    run = 1'b1;
    capture(-1, -1, -1);
    sweep(45, 28, 36);
    pulse_fs();
    check("restore frame_ready", {31'd0, frame_ready}, 32'd1);
    sweep(45, 28, 36);
    sweep(46, 28, 36);
    run = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
